pdm_mic_sequencer: RTL and testbench

- Controller for the microphone-grid front end. Generates the shared PDM microphone clock and select pins, and sequences start, warm-up, run and stop.
- Captures all 32 PDM data lines on both clock phases: channel A is captured during the high half, channel B during the low half.
- Presents one 64-bit sample pair per PDM period to the CIC collector. Sits between the GPIO mic pins and the CIC decimation datapath inside the HPS-attached system.

---
 rtl/pdm_mic_sequencer.sv | 153 +++++++++++++++
 tb/tb_pdm_mic_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_sequencer.sv
// PDM microphone sequencer: drives mic_clock/mic_select and captures both stereo phases on every line.
// Build option MIC_DATA_SYNC_EN inserts a 2-flop synchronizer on mic_data ahead of capture.
`timescale 1ns/1ps
module pdm_mic_sequencer #(
  parameter int N_LINES        = 32,
  parameter int DIV_HALF       = 16,
  parameter int WARMUP_PERIODS = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_select,
  input  logic [N_LINES-1:0] mic_data,
  output logic               mic_clock,
  output logic               mic_select,
  output logic               busy,
  output logic               running,
  output logic [N_LINES-1:0] pdm_a,
  output logic [N_LINES-1:0] pdm_b,
  output logic               pdm_valid,
  input  logic               pdm_ready,
  output logic [15:0]        overrun_cnt,
  input  logic               overrun_clr
);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, STOPPING} state_t;

  localparam int PH_W    = $clog2(2 * DIV_HALF);
  localparam int WU_W    = (WARMUP_PERIODS > 1) ? $clog2(WARMUP_PERIODS) : 1;
  localparam int WU_LAST = (WARMUP_PERIODS > 0) ? WARMUP_PERIODS - 1 : 0;

  state_t             state;
  logic [PH_W-1:0]    ph;
  logic [PH_W-1:0]    ph_inc;
  logic [WU_W-1:0]    wu_cnt;
  logic [N_LINES-1:0] cap_a;
  logic [N_LINES-1:0] sample;
  logic               stop_in_run;
  logic               at_a;
  logic               at_wrap;
  logic               high_next;

`ifdef MIC_DATA_SYNC_EN
  logic [N_LINES-1:0] sync_q1;
  logic [N_LINES-1:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= mic_data;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = mic_data;
`endif

  assign at_a      = (ph == PH_W'(DIV_HALF - 1));
  assign at_wrap   = (ph == PH_W'(2 * DIV_HALF - 1));
  assign ph_inc    = at_wrap ? '0 : ph + PH_W'(1);
  assign high_next = (ph_inc < PH_W'(DIV_HALF));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ph          <= '0;
      wu_cnt      <= '0;
      stop_in_run <= 1'b0;
      cap_a       <= '0;
      mic_clock   <= 1'b0;
      mic_select  <= 1'b0;
      busy        <= 1'b0;
      running     <= 1'b0;
      pdm_a       <= '0;
      pdm_b       <= '0;
      pdm_valid   <= 1'b0;
    end else begin
      pdm_valid <= 1'b0;
      if (state == IDLE) begin
        if (start && !stop) begin
          mic_select <= cfg_select;
          ph         <= '0;
          mic_clock  <= 1'b1;
          busy       <= 1'b1;
          wu_cnt     <= '0;
          if (WARMUP_PERIODS == 0) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            state <= WARMUP;
          end
        end
      end else begin
        ph        <= ph_inc;
        mic_clock <= high_next;
        if (at_a) cap_a <= sample;
        // The B half is taken straight into pdm_b so the strobe lands one cycle after the capture.
        if (at_wrap && (state == RUN || (state == STOPPING && stop_in_run))) begin
          pdm_a     <= cap_a;
          pdm_b     <= sample;
          pdm_valid <= 1'b1;
        end
        case (state)
          WARMUP: begin
            if (stop) begin
              stop_in_run <= 1'b0;
              state       <= STOPPING;
            end else if (at_wrap) begin
              if (wu_cnt == WU_W'(WU_LAST)) begin
                state   <= RUN;
                running <= 1'b1;
              end else begin
                wu_cnt <= wu_cnt + WU_W'(1);
              end
            end
          end
          RUN: begin
            if (stop) begin
              stop_in_run <= 1'b1;
              state       <= STOPPING;
              running     <= 1'b0;
            end
          end
          default: ;
        endcase
        // A stop arriving on the wrap cycle completes that same period, so STOPPING is skipped.
        if (at_wrap && (state == STOPPING || stop)) begin
          state     <= IDLE;
          busy      <= 1'b0;
          running   <= 1'b0;
          ph        <= '0;
          mic_clock <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (overrun_clr) begin
      overrun_cnt <= '0;
    end else if (pdm_valid && !pdm_ready && overrun_cnt != 16'hFFFF) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pdm_mic_sequencer.sv
// Scoreboard bench for pdm_mic_sequencer: a cycle-timeline model predicts clock, status, strobes and overruns.
`timescale 1ns/1ps
module tb_pdm_mic_sequencer;
  localparam int N   = 32;
  localparam int DH  = 4;
  localparam int W   = 2;
  localparam int PER = 2 * DH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_select = 1'b0;
  logic          pdm_ready = 1'b1;
  logic          overrun_clr = 1'b0;
  logic [N-1:0]  mic_data = '0;
  logic          mic_clock, mic_select, busy, running, pdm_valid;
  logic [N-1:0]  pdm_a, pdm_b;
  logic [15:0]   overrun_cnt;

  pdm_mic_sequencer #(.N_LINES(N), .DIV_HALF(DH), .WARMUP_PERIODS(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_select(cfg_select),
    .mic_data(mic_data), .mic_clock(mic_clock), .mic_select(mic_select), .busy(busy),
    .running(running), .pdm_a(pdm_a), .pdm_b(pdm_b), .pdm_valid(pdm_valid),
    .pdm_ready(pdm_ready), .overrun_cnt(overrun_cnt), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Session timeline: periods start at t_start+1 every PER cycles; p_last is the final strobing period.
  int          t_start = -1000;
  int          t_end = -1000;
  int          s_cyc = -1000;
  int          p_last = -1;
  bit          sel_exp = 1'b0;
  int          ov_exp = 0;
  bit          ready_forced = 1'b0;
  int          clr_cyc = -1;
  int          clr_cyc2 = -1;
  logic [31:0] a_arr [0:15];
  logic [31:0] b_arr [0:15];

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } strobe_t;
  strobe_t sb_q[$];

  int assertions = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_active(input int c);
    return (c >= t_start + 1) && (c < t_end);
  endfunction

  function automatic bit m_high(input int c);
    return m_active(c) && (((c - t_start - 1) % PER) < DH);
  endfunction

  function automatic bit m_running(input int c);
    return m_active(c) && (c >= t_start + 1 + W * PER) && (c <= s_cyc);
  endfunction

  function automatic bit m_strobe(input int c);
    int q;
    int p;
    q = c - t_start - 1;
    if (q <= 0 || (q % PER) != 0) return 1'b0;
    p = q / PER - 1;
    return (p >= W) && (p <= p_last);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-half data driver: value held across each half of every modelled period.
  always @(posedge clk) begin
    int q;
    #1;
    if (cyc >= t_start + 1 && cyc < t_end) begin
      q = cyc - t_start - 1;
      mic_data = ((q % PER) < DH) ? a_arr[q / PER] : b_arr[q / PER];
    end else begin
      mic_data = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_forced) begin
      pdm_ready   = 1'b0;
      overrun_clr = (cyc == clr_cyc) || (cyc == clr_cyc2);
    end else begin
      pdm_ready   = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 39) == 0);
    end
  end

  // Status checker and overrun reference model.
  always @(negedge clk) begin
    if (reset) ov_exp = 0;
    check("mic_clock", 64'(mic_clock), 64'(m_high(cyc)));
    check("busy", 64'(busy), 64'(m_active(cyc)));
    check("running", 64'(running), 64'(m_running(cyc)));
    check("mic_select", 64'(mic_select), 64'(sel_exp));
    check("overrun_cnt", 64'(overrun_cnt), 64'(ov_exp));
    if (!reset) begin
      if (overrun_clr) ov_exp = 0;
      else if (m_strobe(cyc) && !pdm_ready && ov_exp < 65535) ov_exp++;
    end
  end

  // Strobe monitor: pops the scoreboard whenever the DUT presents pdm_valid.
  always @(negedge clk) begin
    strobe_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      assertions++;
      failures++;
      $display("FAIL strobe_missing: no pdm_valid at cycle %0d, expected a=%h b=%h", e.cyc, e.a, e.b);
    end
    if (pdm_valid) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        check("pdm_a", 64'(pdm_a), 64'(e.a));
        check("pdm_b", 64'(pdm_b), 64'(e.b));
      end else begin
        assertions++;
        failures++;
        $display("FAIL strobe_unexpected: pdm_valid=1 at cycle %0d, expected 0", cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0;
      stop = 1'b0;
      cfg_select = 1'($urandom);
      step();
    end
  endtask

  // p_s/ph_s: period index and phase at which stop is pulsed; rst_at>0 resets at t_start+rst_at instead.
  task automatic run_session(input int p_s, input int ph_s, input bit sel, input bit fixed_data,
                             input bit forced, input int rst_at);
    int t;
    step();
    t = cyc + 1;
    for (int p = 0; p < 16; p++) begin
      a_arr[p] = fixed_data ? 32'hA5A5A5A5 : $urandom;
      b_arr[p] = fixed_data ? 32'h5A5A5A5A : $urandom;
    end
    t_start = t;
    t_end   = t + 1 + (p_s + 1) * PER;
    s_cyc   = (rst_at > 0) ? t_end + 100 : t + 1 + p_s * PER + ph_s;
    p_last  = p_s;
    for (int p = W; p <= p_s; p++) sb_q.push_back('{t + 1 + (p + 1) * PER, a_arr[p], b_arr[p]});
    clr_cyc  = t;
    clr_cyc2 = t + 1 + (W + 4) * PER;
    ready_forced = forced;
    step();
    start = 1'b1;
    stop = 1'b0;
    cfg_select = sel;
    step();
    start = 1'b0;
    sel_exp = sel;
    while (cyc <= t_end + 1) begin
      if (rst_at > 0 && cyc == t + rst_at) begin
        reset = 1'b1;
        t_end = cyc;
        p_last = -1;
        sel_exp = 1'b0;
        sb_q.delete();
        step();
        step();
        reset = 1'b0;
        break;
      end
      stop  = (cyc == s_cyc);
      start = (cyc > t + W * PER) && (cyc < s_cyc) && ($urandom_range(0, 3) == 0);
      cfg_select = 1'($urandom);
      step();
    end
    stop = 1'b0;
    start = 1'b0;
    ready_forced = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    idle(2);
    run_session(5, 2, 1'b1, 1'b1, 1'b0, 0);
    idle(3);
    run_session(W + 3, 0, 1'b0, 1'b0, 1'b1, 0);
    idle(2);
    run_session(1, 3, 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    start = 1'b1;
    stop = 1'b1;
    cfg_select = ~sel_exp;
    step();
    start = 1'b0;
    stop = 1'b0;
    idle(10);
    run_session(6, 0, 1'b1, 1'b0, 1'b0, 1 + (W + 1) * PER + 3);
    idle(2);
    run_session(3, 5, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 5));
      run_session($urandom_range(0, 6), $urandom_range(0, PER - 1), 1'($urandom), 1'b0, 1'b0, 0);
    end
    idle(4);
    if (sb_q.size() != 0) begin
      assertions++;
      failures++;
      $display("FAIL strobe_leftover: %0d expected strobes never seen, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
